// File: rtl/tns_decoder_12.sv
// tns_decoder_12: weighted-sum decoder for 12-bit TNS codewords.
// Two-stage valid/ready pipeline with an out-of-range flag and a saturating error count.
`default_nettype none

module tns_decoder_12 (
  input  logic        clock,
  input  logic        rst,
  input  logic [11:0] codein,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  dataout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        dec_err,
  output logic [15:0] err_cnt
);

  // Values shared with the 12-bit encoder (TNS.vh)
  localparam int BLEN04 = 8;
  localparam int PW     = BLEN04 + 1;
  localparam int SW     = BLEN04 + 2;

  localparam logic [PW-1:0] TNS04_A = PW'(233);
  localparam logic [PW-1:0] TNS04_B = PW'(144);
  localparam logic [PW-1:0] TNS04_C = PW'(89);
  localparam logic [PW-1:0] TNS03_A = PW'(55);
  localparam logic [PW-1:0] TNS03_B = PW'(34);
  localparam logic [PW-1:0] TNS03_C = PW'(21);
  localparam logic [PW-1:0] TNS02_A = PW'(13);
  localparam logic [PW-1:0] TNS02_B = PW'(8);
  localparam logic [PW-1:0] TNS02_C = PW'(5);
  localparam logic [PW-1:0] TNS01_A = PW'(3);
  localparam logic [PW-1:0] TNS01_B = PW'(2);
  localparam logic [PW-1:0] C_ZERO  = '0;
  localparam logic [PW-1:0] C_ONE   = PW'(1);

  logic          r_s1_valid;
  logic [PW-1:0] r_p4, r_p3, r_p2, r_p1;

  logic          w_s2_free, w_s1_adv, w_accept, w_deliver;
  logic [PW-1:0] w_p4, w_p3, w_p2, w_p1;
  logic [SW-1:0] w_sum;

  assign w_s2_free = !out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  // Group partial sums never exceed 466, so PW bits cannot overflow
  assign w_p4 = (codein[11] ? TNS04_A : C_ZERO) + (codein[10] ? TNS04_B : C_ZERO)
              + (codein[9]  ? TNS04_C : C_ZERO);
  assign w_p3 = (codein[8]  ? TNS03_A : C_ZERO) + (codein[7]  ? TNS03_B : C_ZERO)
              + (codein[6]  ? TNS03_C : C_ZERO);
  assign w_p2 = (codein[5]  ? TNS02_A : C_ZERO) + (codein[4]  ? TNS02_B : C_ZERO)
              + (codein[3]  ? TNS02_C : C_ZERO);
  assign w_p1 = (codein[2]  ? TNS01_A : C_ZERO) + (codein[1]  ? TNS01_B : C_ZERO)
              + (codein[0]  ? C_ONE   : C_ZERO);

  assign w_sum = {1'b0, r_p4} + {1'b0, r_p3} + {1'b0, r_p2} + {1'b0, r_p1};

  always_ff @(posedge clock) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p4       <= '0;
      r_p3       <= '0;
      r_p2       <= '0;
      r_p1       <= '0;
      out_valid  <= 1'b0;
      dataout    <= '0;
      dec_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_p4       <= w_p4;
        r_p3       <= w_p3;
        r_p2       <= w_p2;
        r_p1       <= w_p1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        out_valid <= 1'b1;
        dataout   <= w_sum[BLEN04-1:0];
        dec_err   <= (w_sum[SW-1:BLEN04] != 2'b00);
      end else if (w_deliver) begin
        out_valid <= 1'b0;
      end

      if (w_deliver && dec_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tns_decoder_12.sv
// tb_tns_decoder_12: randomized and directed checks of tns_decoder_12 against a weight-sum scoreboard.
`default_nettype none

module tb_tns_decoder_12;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] codein = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  dataout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        dec_err;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rnd_ready = 1'b0;

  logic [8:0]  exp_q[$];
  logic [15:0] model_cnt = '0;
  bit          held_v = 1'b0;
  logic [8:0]  held_val = '0;

  tns_decoder_12 dut (
    .clock(clock), .rst(rst), .codein(codein), .in_valid(in_valid),
    .in_ready(in_ready), .dataout(dataout), .out_valid(out_valid),
    .out_ready(out_ready), .dec_err(dec_err), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Fibonacci weights: bit0 = 1, bit1 = 2, each next bit the sum of the two below
  function automatic int weight(input int b);
    int a = 1, c = 2, t;
    if (b == 0) return 1;
    for (int k = 1; k < b; k++) begin
      t = a + c; a = c; c = t;
    end
    return c;
  endfunction

  function automatic logic [8:0] ref_decode(input logic [11:0] cw);
    int s = 0;
    for (int b = 0; b < 12; b++) if (cw[b]) s += weight(b);
    return {(s >= 256), 8'(s % 256)};
  endfunction

  // Greedy Zeckendorf form, as the encoder's subtract chain produces
  function automatic logic [11:0] encode(input int v);
    logic [11:0] cw = '0;
    int r = v;
    for (int b = 11; b >= 0; b--) begin
      if (weight(b) <= r) begin
        cw[b] = 1'b1;
        r -= weight(b);
      end
    end
    return cw;
  endfunction

  always @(negedge clock) begin
    logic [8:0] e;
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
      held_v = 1'b0;
    end else begin
      check("err_cnt", err_cnt, model_cnt);
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {dec_err, dataout}, held_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("dataout", dataout, e[7:0]);
          check("dec_err", dec_err, e[8]);
          if (e[8] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
      end
      held_v   = out_valid && !out_ready;
      held_val = {dec_err, dataout};
      if (in_valid && in_ready) exp_q.push_back(ref_decode(codein));
    end
  end

  always @(posedge clock) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [11:0] cw);
    bit acc = 1'b0;
    codein   = cw;
    in_valid = 1'b1;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    int t = 0;
    in_valid  = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while (t < 200 && (exp_q.size() != 0 || out_valid)) begin
      @(negedge clock);
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int start;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dataout", dataout, 0);
    check("rst_dec_err", dec_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clock); #1;

    // Zero and LSB with latency probe
    send(12'h000);
    in_valid = 1'b0;
    @(negedge clock);
    check("lat_s1", out_valid, 0);
    @(negedge clock);
    check("lat_out_valid", out_valid, 1);
    check("lat_data0", dataout, 0);
    @(posedge clock); #1;
    send(12'h001);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("lsb_data", dataout, 1);
    check("lsb_err", dec_err, 0);
    drain();

    // One-hot walk, back-to-back
    @(posedge clock); #1;
    start = cyc;
    for (int b = 11; b >= 0; b--) send(12'(1) << b);
    check("walk_cycles", cyc - start, 12);
    drain();

    // Round trip through the encoder model, repeating values
    @(posedge clock); #1;
    for (int v = 0; v < 256; v++) begin
      send(encode(v));
      if (v % 17 == 0) send(encode(v));
    end
    drain();
    check("rt_err_cnt", err_cnt, 0);

    // Backpressure
    @(posedge clock); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(encode(40 + i * 50));
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      send(12'($urandom));
    end
    drain();

    // Out-of-range and saturation
    @(posedge clock); #1;
    send(12'hFFF);
    drain();
    check("oor_err_cnt1", err_cnt, model_cnt);
    check("oor_data", dataout, 8'd96);
    check("oor_flag", dec_err, 1);
    @(posedge clock); #1;
    for (int i = 0; i < 65534; i++) send(12'hFFF);
    drain();
    check("sat_reach", err_cnt, 16'hFFFF);
    @(posedge clock); #1;
    send(12'hFFF);
    drain();
    check("sat_hold", err_cnt, 16'hFFFF);

    // Reset with both stages full
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(encode(100));
    send(12'hFFF);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_dataout", dataout, 0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(encode(77));
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_data", dataout, 77);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
